cep_cpu_wr_arb: RTL and testbench
=================================

CEP_CPU_WR_ARB -- requirements
Module: cep_cpu_wr_arb

Interface
REQ-001 SHALL have parameter LOGICALWIDTH, default 32, logical write-data width.
REQ-002 SHALL have parameter ADDRWIDTH, default 10, memory address width.
REQ-003 SHALL have parameter CODE_PORT_WIDTH, default 1, check-bit injection width.
REQ-004 SHALL have parameter STARVE_LIMIT, default 15, number of PEND cycles lost to HW before hwStall asserts; range 1..255.
REQ-005 SHALL use one clock and a synchronous, active-high reset: clk  in  1  rising-edge clock; rst  in  1  synchronous active-high reset.
REQ-006 hwWrEn  in  1  HW write this cycle.
REQ-007 hwWrAddr  in  ADDRWIDTH  HW write address.
REQ-008 hwWrData  in  LOGICALWIDTH  HW logical write data.
REQ-009 cpuReqValid  in  1  CPU write request valid.
REQ-010 cpuReqReady  out  1  arbiter can accept a CPU request.
REQ-011 cpuReqAddr  in  ADDRWIDTH  CPU write address.
REQ-012 cpuReqData  in  LOGICALWIDTH  CPU logical write data.
REQ-013 cpuReqProtOverride  in  1  CPU request uses forced check bits.
REQ-014 cpuReqCheckBits  in  CODE_PORT_WIDTH  forced check-bit value.
REQ-015 cpuDone  out  1  one-cycle pulse, CPU write committed.
REQ-016 hwStall  out  1  request to HW source to withhold writes.
REQ-017 memWrEn  out  1  memory write strobe.
REQ-018 memWrAddr  out  ADDRWIDTH  memory write address.
REQ-019 hwUnprLogiDin  out  LOGICALWIDTH  HW data to DIN path (equals hwWrData).
REQ-020 cpuUnprLogiDin  out  LOGICALWIDTH  latched CPU data to DIN path.
REQ-021 hwActive  out  1  HW owns this write cycle (equals hwWrEn).
REQ-022 protOverride  out  1  override to DIN path check-bit generators.
REQ-023 checkBitsIn  out  CODE_PORT_WIDTH  latched forced check bits to DIN path.

Function
REQ-024 SHALL implement FSM states IDLE, PEND, DONE.
REQ-025 cpuReqReady SHALL be 1 only in IDLE; valid&ready in cycle N SHALL latch addr/data/override/checkbits and enter PEND at N+1.
REQ-026 In PEND with hwWrEn=0: CPU granted same cycle -- memWrEn=1, memWrAddr=latched addr, protOverride=latched override; next state DONE.
REQ-027 In PEND with hwWrEn=1: HW wins, CPU stays PEND; starve counter increments, saturating at STARVE_LIMIT.
REQ-028 DONE SHALL last exactly one cycle, cpuDone=1, then IDLE; minimum request-to-cpuDone latency 2 cycles.
REQ-029 Whenever hwWrEn=1: memWrEn=1, memWrAddr=hwWrAddr, protOverride=0, in any state.
REQ-030 protOverride SHALL be 0 in every cycle without a CPU grant.
REQ-031 cpuUnprLogiDin and checkBitsIn SHALL hold latched values until the next accepted request.
REQ-032 Starve counter SHALL clear on CPU grant and on entry to PEND.
REQ-033 hwStall SHALL be registered: 1 from the cycle after counter reaches STARVE_LIMIT until the CPU grant cycle inclusive, 0 the cycle after.
REQ-034 HW priority SHALL be absolute; hwStall is advisory only and never blocks hwWrEn.

Reset
REQ-035 rst=1 at a clock edge SHALL force IDLE, counter 0, latched fields 0, hwStall 0, cpuDone 0; a pending CPU request is dropped with no cpuDone.
REQ-036 During rst, memWrEn SHALL equal hwWrEn and no CPU write SHALL occur.

Configuration
REQ-037 Macro CEP_WR_ARB_STARVE_EN SHALL compile in the starve counter and hwStall logic; undefined, hwStall is tied 0, no counter exists, and CPU waits indefinitely behind HW.

Verification
REQ-038 Idle HW, CPU writes addr 0x005 data 0xDEADBEEF at N -> memWrEn/addr 0x005 at N+1 with hwActive=0, cpuDone at N+2, ready at N+3.
REQ-039 hwWrEn held 1 for 5 cycles after CPU accept -> no CPU write; grant on first hwWrEn=0 cycle; memWrAddr follows hwWrAddr meanwhile.
REQ-040 CEP_WR_ARB_STARVE_EN, STARVE_LIMIT=3, hwWrEn stuck 1 -> hwStall=1 after 3 lost cycles; drop hwWrEn -> grant, hwStall=0 next cycle.
REQ-041 cpuReqProtOverride=1, checkBits=1 -> protOverride=1 only in grant cycle; interleaved HW write cycles show protOverride=0.
REQ-042 rst asserted in PEND -> IDLE next cycle, no memWrEn from CPU, no cpuDone, cpuReqReady=1.

Source files
------------

// File: rtl/cep_cpu_wr_arb.sv
// cep_cpu_wr_arb: arbitrates one memory write port between a HW source
// (absolute priority) and a single outstanding CPU write request.
//
// Ports:
//   clk, rst             rising-edge clock, synchronous active-high reset
//   hwWrEn/Addr/Data     HW write, always wins the port
//   cpuReq*              CPU request (valid/ready), latched on accept
//   cpuDone              one-cycle pulse after the CPU write is committed
//   hwStall              advisory request for HW to back off
//   memWrEn/memWrAddr    memory write strobe and address
//   hwUnprLogiDin        HW data to DIN path
//   cpuUnprLogiDin       latched CPU data to DIN path
//   hwActive             HW owns this write cycle
//   protOverride         forced check bits select for DIN path
//   checkBitsIn          latched forced check bits
//
// Build option: define CEP_WR_ARB_STARVE_EN to include the starve counter
// and hwStall; otherwise hwStall is 0 and the CPU waits behind HW forever.

module cep_cpu_wr_arb #(
    parameter int LOGICALWIDTH    = 32,
    parameter int ADDRWIDTH       = 10,
    parameter int CODE_PORT_WIDTH = 1,
    parameter int STARVE_LIMIT    = 15
) (
    input  logic                       clk,
    input  logic                       rst,

    input  logic                       hwWrEn,
    input  logic [ADDRWIDTH-1:0]       hwWrAddr,
    input  logic [LOGICALWIDTH-1:0]    hwWrData,

    input  logic                       cpuReqValid,
    output logic                       cpuReqReady,
    input  logic [ADDRWIDTH-1:0]       cpuReqAddr,
    input  logic [LOGICALWIDTH-1:0]    cpuReqData,
    input  logic                       cpuReqProtOverride,
    input  logic [CODE_PORT_WIDTH-1:0] cpuReqCheckBits,
    output logic                       cpuDone,
    output logic                       hwStall,

    output logic                       memWrEn,
    output logic [ADDRWIDTH-1:0]       memWrAddr,
    output logic [LOGICALWIDTH-1:0]    hwUnprLogiDin,
    output logic [LOGICALWIDTH-1:0]    cpuUnprLogiDin,
    output logic                       hwActive,
    output logic                       protOverride,
    output logic [CODE_PORT_WIDTH-1:0] checkBitsIn
);

    // The starve counter is 8 bits wide, so the limit must fit in 1..255.
    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 255) begin : g_bad_limit
        $error("STARVE_LIMIT out of range 1..255");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PEND = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                     state;
    logic                       ready_q;
    logic                       done_q;
    logic [ADDRWIDTH-1:0]       lat_addr;
    logic [LOGICALWIDTH-1:0]    lat_data;
    logic                       lat_ovr;
    logic [CODE_PORT_WIDTH-1:0] lat_cb;

    logic accept;
    logic grant;

    assign accept = cpuReqValid & ready_q;

    // CPU gets the port only in PEND, only when HW is quiet, and never
    // while reset is held.
    assign grant = (state == PEND) & ~hwWrEn & ~rst;

    // Single FSM block; ready and done are registered alongside the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            ready_q  <= 1'b1;
            done_q   <= 1'b0;
            lat_addr <= '0;
            lat_data <= '0;
            lat_ovr  <= 1'b0;
            lat_cb   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        state    <= PEND;
                        ready_q  <= 1'b0;
                        lat_addr <= cpuReqAddr;
                        lat_data <= cpuReqData;
                        lat_ovr  <= cpuReqProtOverride;
                        lat_cb   <= cpuReqCheckBits;
                    end
                end
                PEND: begin
                    if (!hwWrEn) begin
                        state  <= DONE;
                        done_q <= 1'b1;
                    end
                end
                DONE: begin
                    state   <= IDLE;
                    done_q  <= 1'b0;
                    ready_q <= 1'b1;
                end
                default: begin
                    state   <= IDLE;
                    done_q  <= 1'b0;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

`ifdef CEP_WR_ARB_STARVE_EN
    localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

    logic [7:0] starve_cnt;
    logic       stall_q;

    // Counts PEND cycles lost to HW. Stall is raised on the edge where the
    // count hits the limit, so it shows from the following cycle and is
    // held through the grant cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= '0;
            stall_q    <= 1'b0;
        end else if (accept) begin
            starve_cnt <= '0;
        end else if (state == PEND) begin
            if (!hwWrEn) begin
                starve_cnt <= '0;
                stall_q    <= 1'b0;
            end else if (starve_cnt != LIMIT) begin
                starve_cnt <= starve_cnt + 8'd1;
                if (starve_cnt + 8'd1 == LIMIT) begin
                    stall_q <= 1'b1;
                end
            end
        end
    end

    assign hwStall = stall_q;
`else
    assign hwStall = 1'b0;
`endif

    assign cpuReqReady    = ready_q;
    assign cpuDone        = done_q;

    // HW always owns the port when it writes, including during reset.
    assign memWrEn        = hwWrEn | grant;
    assign memWrAddr      = hwWrEn ? hwWrAddr : lat_addr;
    assign protOverride   = grant & lat_ovr;

    assign hwActive       = hwWrEn;
    assign hwUnprLogiDin  = hwWrData;
    assign cpuUnprLogiDin = lat_data;
    assign checkBitsIn    = lat_cb;

endmodule

// File: tb/tb_cep_cpu_wr_arb.sv
// tb_cep_cpu_wr_arb: directed scenarios plus randomized traffic checked
// against a transaction-level model of the write arbiter.

module tb_cep_cpu_wr_arb;

    localparam int LW  = 32;
    localparam int AW  = 10;
    localparam int CW  = 1;
    localparam int LIM = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          hwWrEn;
    logic [AW-1:0] hwWrAddr;
    logic [LW-1:0] hwWrData;
    logic          cpuReqValid;
    logic          cpuReqReady;
    logic [AW-1:0] cpuReqAddr;
    logic [LW-1:0] cpuReqData;
    logic          cpuReqProtOverride;
    logic [CW-1:0] cpuReqCheckBits;
    logic          cpuDone;
    logic          hwStall;
    logic          memWrEn;
    logic [AW-1:0] memWrAddr;
    logic [LW-1:0] hwUnprLogiDin;
    logic [LW-1:0] cpuUnprLogiDin;
    logic          hwActive;
    logic          protOverride;
    logic [CW-1:0] checkBitsIn;

    cep_cpu_wr_arb #(
        .LOGICALWIDTH(LW),
        .ADDRWIDTH(AW),
        .CODE_PORT_WIDTH(CW),
        .STARVE_LIMIT(LIM)
    ) dut (
        .clk(clk),
        .rst(rst),
        .hwWrEn(hwWrEn),
        .hwWrAddr(hwWrAddr),
        .hwWrData(hwWrData),
        .cpuReqValid(cpuReqValid),
        .cpuReqReady(cpuReqReady),
        .cpuReqAddr(cpuReqAddr),
        .cpuReqData(cpuReqData),
        .cpuReqProtOverride(cpuReqProtOverride),
        .cpuReqCheckBits(cpuReqCheckBits),
        .cpuDone(cpuDone),
        .hwStall(hwStall),
        .memWrEn(memWrEn),
        .memWrAddr(memWrAddr),
        .hwUnprLogiDin(hwUnprLogiDin),
        .cpuUnprLogiDin(cpuUnprLogiDin),
        .hwActive(hwActive),
        .protOverride(protOverride),
        .checkBitsIn(checkBitsIn)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model: one outstanding CPU request, a done flag for the cycle after
    // it is written, and the number of cycles it has lost to HW.
    bit            m_pend;
    bit            m_done;
    logic [AW-1:0] m_addr;
    logic [LW-1:0] m_data;
    bit            m_ovr;
    logic [CW-1:0] m_cb;
    int            m_lost;
    bit            m_stall;
    int            grants;
    int            stalls;

    task automatic model_reset();
        m_pend  = 0;
        m_done  = 0;
        m_addr  = '0;
        m_data  = '0;
        m_ovr   = 0;
        m_cb    = '0;
        m_lost  = 0;
        m_stall = 0;
    endtask

    // Drives one cycle of inputs, checks outputs mid-cycle, then advances
    // the model over the clock edge.
    task automatic step(input bit r, input bit hw, input logic [AW-1:0] ha,
                        input logic [LW-1:0] hd, input bit v,
                        input logic [AW-1:0] ca, input logic [LW-1:0] cd,
                        input bit po, input logic [CW-1:0] cb);
        bit ready;
        bit grant;
        bit acc;
        rst                = r;
        hwWrEn             = hw;
        hwWrAddr           = ha;
        hwWrData           = hd;
        cpuReqValid        = v;
        cpuReqAddr         = ca;
        cpuReqData         = cd;
        cpuReqProtOverride = po;
        cpuReqCheckBits    = cb;
        #1;
        ready = !m_pend && !m_done;
        grant = m_pend && !hw && !r;
        chk("ready", 64'(cpuReqReady), 64'(ready));
        chk("done", 64'(cpuDone), 64'(m_done));
        chk("memWrEn", 64'(memWrEn), 64'(hw | grant));
        if (hw | grant)
            chk("memWrAddr", 64'(memWrAddr), 64'(hw ? ha : m_addr));
        chk("protOverride", 64'(protOverride), 64'(grant & m_ovr));
        chk("hwActive", 64'(hwActive), 64'(hw));
        chk("hwDin", 64'(hwUnprLogiDin), 64'(hd));
        chk("cpuDin", 64'(cpuUnprLogiDin), 64'(m_data));
        chk("checkBits", 64'(checkBitsIn), 64'(m_cb));
`ifdef CEP_WR_ARB_STARVE_EN
        chk("hwStall", 64'(hwStall), 64'(m_stall));
`else
        chk("hwStall", 64'(hwStall), 64'(0));
`endif
        if (grant) grants++;
        if (m_stall) stalls++;
        @(posedge clk);
        if (r) begin
            model_reset();
        end else begin
            acc = ready && v;
            if (grant) begin
                m_pend  = 0;
                m_lost  = 0;
                m_stall = 0;
            end else if (m_pend && hw) begin
                if (m_lost < LIM) m_lost++;
                if (m_lost == LIM) m_stall = 1;
            end
            if (acc) begin
                m_pend = 1;
                m_addr = ca;
                m_data = cd;
                m_ovr  = po;
                m_cb   = cb;
                m_lost = 0;
            end
            m_done = grant;
        end
        #1;
    endtask

    task automatic idle(input bit hw, input int n);
        for (int i = 0; i < n; i++)
            step(0, hw, AW'($urandom), $urandom, 0, '0, '0, 0, '0);
    endtask

    initial begin
        int dens;
        grants = 0;
        stalls = 0;
        rst = 1;
        hwWrEn = 0;
        hwWrAddr = '0;
        hwWrData = '0;
        cpuReqValid = 0;
        cpuReqAddr = '0;
        cpuReqData = '0;
        cpuReqProtOverride = 0;
        cpuReqCheckBits = '0;
        @(posedge clk);
        #1;
        model_reset();

        // reset held, HW still writes through
        step(1, 1, 10'h3a, 32'h1234, 1, 10'h1, 32'h1, 1, 1'b1);
        step(1, 0, 10'h3b, 32'h5678, 0, '0, '0, 0, '0);

        // idle HW, simple CPU write
        step(0, 0, '0, '0, 1, 10'h005, 32'hDEADBEEF, 0, '0);
        idle(0, 3);

        // HW holds the port for 5 cycles after accept
        step(0, 0, '0, '0, 1, 10'h0a1, 32'hCAFEF00D, 0, '0);
        for (int i = 0; i < 5; i++)
            step(0, 1, AW'(10'h100 + i), $urandom, 0, '0, '0, 0, '0);
        idle(0, 3);

        // forced check bits with interleaved HW writes
        step(0, 0, '0, '0, 1, 10'h2f0, 32'h0badcafe, 1, 1'b1);
        step(0, 1, 10'h011, 32'h11, 0, '0, '0, 0, '0);
        step(0, 1, 10'h012, 32'h12, 0, '0, '0, 0, '0);
        idle(0, 3);

        // stuck HW beyond the starve limit, then release
        step(0, 0, '0, '0, 1, 10'h077, 32'h77, 0, '0);
        idle(1, 6);
        idle(0, 3);

        // reset while pending
        step(0, 0, '0, '0, 1, 10'h1ff, 32'h1ff, 1, 1'b1);
        step(0, 1, 10'h040, 32'h40, 0, '0, '0, 0, '0);
        step(1, 0, '0, '0, 0, '0, '0, 0, '0);
        idle(0, 3);

        for (int i = 0; i < 3000; i++) begin
            case ((i / 150) % 3)
                0: dens = 10;
                1: dens = 50;
                default: dens = 95;
            endcase
            step(($urandom % 80) == 0,
                 ($urandom % 100) < dens,
                 AW'($urandom), $urandom,
                 $urandom_range(0, 1) == 1,
                 AW'($urandom), $urandom,
                 $urandom_range(0, 1) == 1, CW'($urandom));
        end

        chk("grants_seen", 64'(grants > 20), 64'(1));
`ifdef CEP_WR_ARB_STARVE_EN
        chk("stalls_seen", 64'(stalls > 0), 64'(1));
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
